life_grid_engine: RTL
=====================

// Module: life_grid_engine
// PURPOSE
//  Cell-grid datapath downstream of the game control FSM. Holds the ROWSxCOLS 1-bit playfield
//  and consumes the FSM's loadData/readData/writeout/restart strobes. Computes the next Conway
//  generation one cell per clock with toroidal wrap and commits it on writeout.
//  Returns lose_sig (FSM loseSig) and scan_done, which paces the FSM's IREAD state.
// PARAMETERS
//  ROWS   8   grid rows
//  COLS   8   grid columns (row width)
//  GEN_W  9   generation counter width (matches FSM 9-bit count)
// PORTS
//  clka       in   1                 single clock; all state updates on posedge
//  reset      in   1                 asynchronous, active-high; clears all state
//  restart    in   1                 sync clear of grids, pointers, flags
//  load_data  in   1                 write row_in into cur_grid[load_ptr]
//  row_in     in   COLS              seed row data
//  read_data  in   1                 level; start/continue generation scan
//  write_out  in   1                 commit nxt_grid to cur_grid
//  row_sel    in   $clog2(ROWS)      display read row select
//  row_out    out  COLS              registered cur_grid[row_sel], 1-cycle latency
//  scan_done  out  1                 full scan finished; nxt_grid valid
//  lose_sig   out  1                 sticky: committed grid is dead
//  gen_count  out  GEN_W             committed generations, saturating
// BEHAVIOUR
//  Reset: all grids 0, load_ptr 0, scan_idx 0, state IDLE; every output 0.
//  Cell (r,c) = cur_grid[r][c]; scan order row-major, idx = r*COLS+c, N = ROWS*COLS.
//  Priority each edge: restart > load_data > write_out > read_data.
//  States:
//   IDLE: read_data=1 -> SCAN, scan_idx<=0; write_out ignored.
//   SCAN: each edge nxt_grid[idx] <= rule(cur cell, 8 neighbours, wrap mod ROWS/COLS);
//         idx==N-1 -> DONE, scan_done<=1. read_data dropping mid-scan does not stall.
//   DONE: scan_done held 1; write_out -> cur_grid<=nxt_grid, gen_count+1 (sat at all-ones),
//         lose_sig <= (nxt_grid==0), scan_done<=0, -> IDLE. Waits indefinitely otherwise.
//  Latency: read_data sampled at edge 0; scan_done seen 1 after edge N (N+1 edges total).
//  Rule: live with 2 or 3 live neighbours -> live; dead with exactly 3 -> live; else dead.
//  Neighbour count 4 bits, 0..8; neighbour set is always exactly 8 cells (wrap).
//  load_data: cur_grid[load_ptr]<=row_in; load_ptr wraps ROWS-1->0; lose_sig, gen_count
//   cleared; any SCAN/DONE aborted -> IDLE, scan_done 0. Load of ROWS+1 rows overwrites row 0.
//  restart: cur_grid, nxt_grid, load_ptr, gen_count, lose_sig, scan_done -> 0; state IDLE.
//  lose_sig cleared only by reset, restart, load_data.
//  row_out updates every edge regardless of state; shows cur_grid (committed), never nxt_grid.
// CONFIGURATION
//  LIFE_STABLE_DETECT_EN defined: on commit lose_sig <= (nxt_grid==0) | (nxt_grid==cur_grid)
//   (still life ends game). Undefined: lose_sig on extinction only; no equality compare logic.
// STRUCTURE
//  Package life_pkg: ROWS/COLS defaults, IDX_W=$clog2(ROWS*COLS), state enum
//   {IDLE,SCAN,DONE}, rule thresholds SURVIVE_LO=2, SURVIVE_HI=3, BIRTH=3.
//  Sub-module life_cell_rule: comb; inputs alive + 8 neighbour bits; output next state.
//  Top: state reg, scan_idx/row/col counters, neighbour mux with wrap, grid regs.
// TESTING
//  Blinker: load rows 3:=0x1C, rest 0; read_data until scan_done, write_out -> rows
//   2,3,4=0x08; second gen -> row 3=0x1C; gen_count=2, lose_sig=0.
//  Wrap: glider in top-left corner, 4 generations x 8 (32) -> original pattern restored.
//  Extinction: single cell row 0=0x01; one gen -> grid 0, lose_sig=1, gen_count=1.
//  Abort: restart asserted at scan_idx=20 -> scan_done never rises, grid/row_out all 0, IDLE.
//  Simultaneous: in DONE, load_data and write_out same edge -> load wins, no commit,
//   gen_count 0; write_out in IDLE -> no change.
//  Stable (macro on): 2x2 block; one gen -> lose_sig=1; macro off -> lose_sig=0.
//  Async reset mid-scan (scan_idx=40): all outputs 0 same cycle, no clka edge required.
//  Saturation: force GEN_W=2, 5 generations of blinker -> gen_count holds 3.

Source files
------------

// File: rtl/life_pkg.sv
// Shared types and constants for the Conway cell-grid engine: default geometry,
// scan state encoding, survival/birth thresholds and a neighbour popcount helper.
package life_pkg;

  localparam int DEF_ROWS  = 8;
  localparam int DEF_COLS  = 8;
  localparam int DEF_GEN_W = 9;
  localparam int IDX_W     = $clog2(DEF_ROWS * DEF_COLS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SURVIVE_LO = 2;
  localparam int SURVIVE_HI = 3;
  localparam int BIRTH      = 3;

  function automatic logic [3:0] pop8(input logic [7:0] v);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) s = s + {3'b000, v[i]};
    return s;
  endfunction

endpackage

// File: rtl/life_cell_rule.sv
// Combinational Conway rule for one cell: alive flag plus its eight neighbours
// in, next-generation state out.
module life_cell_rule
  import life_pkg::*;
(
  input  logic       i_alive,
  input  logic [7:0] i_nbr,
  output logic       o_next
);

  logic [3:0] w_cnt;

  assign w_cnt  = pop8(i_nbr);
  assign o_next = i_alive ? ((w_cnt >= 4'(SURVIVE_LO)) && (w_cnt <= 4'(SURVIVE_HI)))
                          : (w_cnt == 4'(BIRTH));

endmodule

// File: rtl/life_grid_engine.sv
// Toroidal Game-of-Life grid engine: computes the next generation one cell per
// clock into a shadow grid and commits it on write_out.
// Build option: define LIFE_STABLE_DETECT_EN to also flag a still life on commit.
//
// Handshake: strobes are sampled on each posedge with fixed priority
// restart > load_data > write_out > read_data; scan_done stays high from the end
// of a scan until that result is committed or the scan is aborted.
module life_grid_engine
  import life_pkg::*;
#(
  parameter int ROWS  = DEF_ROWS,
  parameter int COLS  = DEF_COLS,
  parameter int GEN_W = DEF_GEN_W
) (
  input  logic                    clka,
  input  logic                    reset,
  input  logic                    restart,
  input  logic                    load_data,
  input  logic [COLS-1:0]         row_in,
  input  logic                    read_data,
  input  logic                    write_out,
  input  logic [$clog2(ROWS)-1:0] row_sel,
  output logic [COLS-1:0]         row_out,
  output logic                    scan_done,
  output logic                    lose_sig,
  output logic [GEN_W-1:0]        gen_count,
  output state_t                  dbg_state
);

  localparam int ROW_W  = $clog2(ROWS);
  localparam int COL_W  = $clog2(COLS);
  localparam int N      = ROWS * COLS;
  localparam int SIDX_W = $clog2(N);

  state_t                     r_state;
  state_t                     w_next_state;
  logic [ROWS-1:0][COLS-1:0]  r_cur;
  logic [ROWS-1:0][COLS-1:0]  r_nxt;
  logic [ROW_W-1:0]           r_load_ptr;
  logic [ROW_W-1:0]           r_row;
  logic [COL_W-1:0]           r_col;
  logic [SIDX_W-1:0]          r_scan_idx;
  logic [COLS-1:0]            r_row_out;
  logic                       r_scan_done;
  logic                       r_lose;
  logic [GEN_W-1:0]           r_gen;

  logic [ROW_W-1:0]           w_row_up;
  logic [ROW_W-1:0]           w_row_dn;
  logic [COL_W-1:0]           w_col_lf;
  logic [COL_W-1:0]           w_col_rt;
  logic [7:0]                 w_nbr;
  logic                       w_cell_next;
  logic                       w_last;
  logic                       w_lose_hit;

  assign row_out   = r_row_out;
  assign scan_done = r_scan_done;
  assign lose_sig  = r_lose;
  assign gen_count = r_gen;
  assign dbg_state = r_state;

  assign w_last = (r_scan_idx == SIDX_W'(N - 1));

  // Torus: row/column neighbours wrap modulo ROWS/COLS, so every cell has 8.
  assign w_row_up = (r_row == '0) ? ROW_W'(ROWS - 1) : r_row - ROW_W'(1);
  assign w_row_dn = (r_row == ROW_W'(ROWS - 1)) ? '0 : r_row + ROW_W'(1);
  assign w_col_lf = (r_col == '0) ? COL_W'(COLS - 1) : r_col - COL_W'(1);
  assign w_col_rt = (r_col == COL_W'(COLS - 1)) ? '0 : r_col + COL_W'(1);

  assign w_nbr = {r_cur[w_row_up][w_col_lf], r_cur[w_row_up][r_col], r_cur[w_row_up][w_col_rt],
                  r_cur[r_row][w_col_lf],                            r_cur[r_row][w_col_rt],
                  r_cur[w_row_dn][w_col_lf], r_cur[w_row_dn][r_col], r_cur[w_row_dn][w_col_rt]};

  life_cell_rule u_rule (
    .i_alive (r_cur[r_row][r_col]),
    .i_nbr   (w_nbr),
    .o_next  (w_cell_next)
  );

`ifdef LIFE_STABLE_DETECT_EN
  assign w_lose_hit = (r_nxt == '0) || (r_nxt == r_cur);
`else
  assign w_lose_hit = (r_nxt == '0);
`endif

  always_comb begin
    w_next_state = r_state;
    if (restart || load_data) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (read_data) w_next_state = SCAN;
        SCAN:    if (w_last)    w_next_state = DONE;
        DONE:    if (write_out) w_next_state = IDLE;
        default: w_next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clka or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clka or posedge reset) begin
    if (reset) begin
      r_cur       <= '0;
      r_nxt       <= '0;
      r_load_ptr  <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_scan_idx  <= '0;
      r_row_out   <= '0;
      r_scan_done <= 1'b0;
      r_lose      <= 1'b0;
      r_gen       <= '0;
    end else begin
      r_row_out <= r_cur[row_sel];
      if (restart) begin
        r_cur       <= '0;
        r_nxt       <= '0;
        r_load_ptr  <= '0;
        r_row       <= '0;
        r_col       <= '0;
        r_scan_idx  <= '0;
        r_scan_done <= 1'b0;
        r_lose      <= 1'b0;
        r_gen       <= '0;
      end else if (load_data) begin
        r_cur[r_load_ptr] <= row_in;
        r_load_ptr  <= (r_load_ptr == ROW_W'(ROWS - 1)) ? '0 : r_load_ptr + ROW_W'(1);
        r_scan_done <= 1'b0;
        r_lose      <= 1'b0;
        r_gen       <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (read_data) begin
              r_row      <= '0;
              r_col      <= '0;
              r_scan_idx <= '0;
            end
          end
          SCAN: begin
            r_nxt[r_row][r_col] <= w_cell_next;
            r_scan_idx          <= r_scan_idx + SIDX_W'(1);
            if (r_col == COL_W'(COLS - 1)) begin
              r_col <= '0;
              r_row <= (r_row == ROW_W'(ROWS - 1)) ? '0 : r_row + ROW_W'(1);
            end else begin
              r_col <= r_col + COL_W'(1);
            end
            if (w_last) r_scan_done <= 1'b1;
          end
          DONE: begin
            if (write_out) begin
              r_cur       <= r_nxt;
              r_scan_done <= 1'b0;
              r_lose      <= r_lose | w_lose_hit;
              if (r_gen != '1) r_gen <= r_gen + GEN_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
